piso_serial_tx: RTL and testbench



---
 rtl/piso_serial_tx_pkg.sv | 15 +
 rtl/piso_serial_tx.sv | 89 ++++++++
 tb/tb_piso_serial_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter:
// FSM state encoding and the counter-width helper.
package piso_serial_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit-counter width for a frame of w bits; w is always >= 2 here.
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word over valid/ready
// and shifts it out one bit per tick-qualified clock edge.
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             last,
    output logic             dbg_state
);

    localparam int CNT_W = cnt_w(WIDTH);

    // Handshake: a word is taken on a rising edge where load_valid and
    // load_ready are both 1; the source holds din/load_valid until then.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        sdo        = 1'b0;
        sdo_valid  = 1'b0;
        last       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sdo_valid  = 1'b1;
                sdo        = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                last       = last_bit;
                // Accepting during the final bit's tick gives gapless frames.
                load_ready = last_bit & tick;
                if (tick) begin
                    if (!last_bit) begin
                        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_q[WIDTH-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (load_valid) begin
                        shreg_d = din;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a word/bit-index frame model.
module tb_piso_serial_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         tick;
    logic [W-1:0] din;
    logic         load_valid;

    logic ready_m, sdo_m, valid_m, last_m, st_m;
    logic ready_l, sdo_l, valid_l, last_l, st_l;

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rstn(rstn), .tick(tick), .din(din), .load_valid(load_valid),
        .load_ready(ready_m), .sdo(sdo_m), .sdo_valid(valid_m), .last(last_m),
        .dbg_state(st_m)
    );

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rstn(rstn), .tick(tick), .din(din), .load_valid(load_valid),
        .load_ready(ready_l), .sdo(sdo_l), .sdo_valid(valid_l), .last(last_l),
        .dbg_state(st_l)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A frame is just "which word, how many bits already sent".
    bit         m_active;
    logic [W-1:0] m_word;
    int         m_k;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 1'b0;
            m_word   = '0;
            m_k      = 0;
        end else if (!m_active) begin
            if (load_valid) begin
                m_active = 1'b1;
                m_word   = din;
                m_k      = 0;
            end
        end else if (tick) begin
            if (m_k < W - 1) m_k++;
            else if (load_valid) begin
                m_word = din;
                m_k    = 0;
            end else m_active = 1'b0;
        end
    end

    function automatic logic exp_sdo(input bit msb_first);
        if (!m_active) return 1'b0;
        return msb_first ? m_word[W-1-m_k] : m_word[m_k];
    endfunction

    // ---------------- per-cycle compare and stream capture ----------------
    logic [31:0] cap_m, cap_l, cap_mdl, last_mask;
    int          cap_n, valid_cyc;

    task automatic clear_capture();
        cap_m = '0; cap_l = '0; cap_mdl = '0; last_mask = '0;
        cap_n = 0; valid_cyc = 0;
    endtask

    always @(negedge clk) begin
        check("sdo_valid_m", valid_m, m_active);
        check("last_m", last_m, m_active && (m_k == W - 1));
        check("load_ready_m", ready_m, !m_active || ((m_k == W - 1) && tick));
        check("sdo_m", sdo_m, exp_sdo(1'b1));
        check("state_m", st_m, m_active);
        check("sdo_valid_l", valid_l, m_active);
        check("last_l", last_l, m_active && (m_k == W - 1));
        check("load_ready_l", ready_l, !m_active || ((m_k == W - 1) && tick));
        check("sdo_l", sdo_l, exp_sdo(1'b0));
        if (valid_m) valid_cyc++;
        if (valid_m && tick) begin
            cap_m     = {cap_m[30:0], sdo_m};
            cap_l     = {cap_l[30:0], sdo_l};
            cap_mdl   = {cap_mdl[30:0], exp_sdo(1'b1)};
            last_mask = {last_mask[30:0], last_m};
            cap_n++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_one(input logic [W-1:0] w);
        tick = 1'b1; load_valid = 1'b1; din = w;
        step(1);
        load_valid = 1'b0; din = W'($urandom);
        step(9);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0; tick = 1'b0; din = '0; load_valid = 1'b0;
        clear_capture();
        #2;
        check("rst_sdo", sdo_m, 1'b0);
        check("rst_valid", valid_m, 1'b0);
        check("rst_last", last_m, 1'b0);
        step(3);
        rstn = 1'b1;
        step(2);
        check("idle_ready", ready_m, 1'b1);

        // Single frame 0x01, tick always high.
        clear_capture();
        send_one(8'h01);
        check("f01_model", cap_mdl, 32'h01);
        check("f01_msb", cap_m, 32'h01);
        check("f01_lsb", cap_l, 32'h80);
        check("f01_valid_cycles", valid_cyc, 8);
        check("f01_last_mask", last_mask, 32'h01);
        check("f01_idle_ready", ready_m, 1'b1);
        check("f01_idle_valid", valid_m, 1'b0);

        // Tick gating: 0xA5, tick every third cycle.
        clear_capture();
        tick = 1'b0; load_valid = 1'b1; din = 8'hA5;
        step(1);
        load_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick = (i % 3 == 2);
            din  = W'($urandom);
            step(1);
        end
        check("a5_model", cap_mdl, 32'hA5);
        check("a5_msb", cap_m, 32'hA5);
        check("a5_lsb", cap_l, 32'hA5);
        check("a5_valid_cycles", valid_cyc, 24);
        check("a5_bits", cap_n, 8);

        // Back-to-back frames 0xF0 then 0x0F with load_valid held.
        clear_capture();
        tick = 1'b1; load_valid = 1'b1; din = 8'hF0;
        step(1);
        din = 8'h0F;
        step(8);
        load_valid = 1'b0;
        step(9);
        check("b2b_model", cap_mdl, 32'hF00F);
        check("b2b_msb", cap_m, 32'hF00F);
        check("b2b_valid_cycles", valid_cyc, 16);
        check("b2b_last_mask", last_mask, 32'h0101);

        // Reset mid-frame, then a clean frame 0x80.
        tick = 1'b1; load_valid = 1'b1; din = 8'hFF;
        step(1);
        load_valid = 1'b0;
        step(3);
        check("pre_rst_valid", valid_m, 1'b1);
        #2;
        rstn = 1'b0; load_valid = 1'b1; din = 8'hAA;
        #1;
        check("async_sdo", sdo_m, 1'b0);
        check("async_valid", valid_m, 1'b0);
        check("async_ready", ready_m, 1'b1);
        check("async_last", last_m, 1'b0);
        step(2);
        check("rst_hold_valid", valid_m, 1'b0);
        clear_capture();
        rstn = 1'b1; din = 8'h80;
        step(1);
        load_valid = 1'b0;
        step(9);
        check("f80_model", cap_mdl, 32'h80);
        check("f80_msb", cap_m, 32'h80);
        check("f80_lsb", cap_l, 32'h01);
        check("f80_valid_cycles", valid_cyc, 8);

        // Random traffic: tick, load_valid and din all random.
        for (int i = 0; i < 600; i++) begin
            tick       = ($urandom_range(0, 3) != 0);
            load_valid = ($urandom_range(0, 2) == 0);
            din        = W'($urandom);
            step(1);
        end
        load_valid = 1'b0; tick = 1'b1;
        step(12);
        check("end_idle_valid", valid_m, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
